// File: rtl/lighting_pkg.sv
// -----------------------------------------------------------------------------
// lighting_pkg
// Shared widths, FSM state encoding and FIFO entry type for the lighting
// sequencer (lighting_seq) and its output FIFO (lit_tri_fifo).
//   TRI_W : one triangle, {v0, v1, v2}, 48 bits per vertex
//   VEC_W : light direction vector
//   RGB_W : packed 8:8:8 colour
// -----------------------------------------------------------------------------
package lighting_pkg;

  localparam int TRI_W = 144;
  localparam int VEC_W = 48;
  localparam int RGB_W = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT_RD = 3'd2,
    ISSUE   = 3'd3,
    WAIT_LT = 3'd4,
    PUSH    = 3'd5,
    DRAIN   = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic [TRI_W-1:0] triangle;
    logic [RGB_W-1:0] rgb;
  } lit_tri_t;

endpackage

// File: rtl/lit_tri_fifo.sv
// -----------------------------------------------------------------------------
// lit_tri_fifo
// Synchronous FIFO of lit_tri_t entries feeding the rasterizer.
// Ports:
//   clk, areset       : clock, asynchronous active-high reset
//   push, push_data   : write request; ignored while full (pre-pop count)
//   pop               : read request; ignored while empty
//   head              : entry at the read pointer (zero after reset)
//   empty, full       : status from the registered count
//   count             : number of stored entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module lit_tri_fifo
  import lighting_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     push,
  input  lit_tri_t                 push_data,
  input  logic                     pop,
  output lit_tri_t                 head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  lit_tri_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the count before any same-cycle pop, so a pop never
  // makes room for a push in the same cycle.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lighting_seq.sv
// -----------------------------------------------------------------------------
// lighting_seq
// Walks a triangle memory on start, feeds each triangle to the lighting stage,
// collects the colour result and queues lit triangles for the rasterizer.
// Ports:
//   clk, areset                  : clock, asynchronous active-high reset
//   start, tri_count, light_vec,
//   base_rgb                     : frame request (sampled when start accepted)
//   busy, done, err_timeout,
//   cull_count                   : frame status
//   mem_rd, mem_addr, mem_rdata  : triangle memory, read data 1 cycle later
//   lt_en, lt_triangle,
//   lt_light_vec, lt_rgb         : lighting request (held until next lt_en)
//   lt_valid, lt_illuminated,
//   lt_rgb_out                   : lighting result
//   out_valid, out_ready,
//   out_triangle, out_rgb        : output stream (FIFO head)
//   dbg_state, dbg_fifo_count    : FSM state and FIFO occupancy for observation
// Build option: LIGHTING_SEQ_CULL_EN -- when defined, unlit triangles are
// dropped and counted; otherwise they are forwarded with rgb 24'h000000.
// Output handshake: out_valid/out_ready, an entry transfers on any cycle where
// both are high; out_valid never waits on out_ready and the head entry stays
// stable while out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module lighting_seq
  import lighting_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_LAT    = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           tri_count,
  input  logic [VEC_W-1:0]            light_vec,
  input  logic [RGB_W-1:0]            base_rgb,
  output logic                        busy,
  output logic                        done,
  output logic                        err_timeout,
  output logic [15:0]                 cull_count,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [TRI_W-1:0]            mem_rdata,
  output logic                        lt_en,
  output logic [TRI_W-1:0]            lt_triangle,
  output logic [VEC_W-1:0]            lt_light_vec,
  output logic [RGB_W-1:0]            lt_rgb,
  input  logic                        lt_valid,
  input  logic                        lt_illuminated,
  input  logic [RGB_W-1:0]            lt_rgb_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TRI_W-1:0]            out_triangle,
  output logic [RGB_W-1:0]            out_rgb,
  output logic [2:0]                  dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count
);

  localparam int WAIT_W = $clog2(MIN_LAT + TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LAT_MIN = WAIT_W'(MIN_LAT);
  localparam logic [WAIT_W-1:0] LAT_MAX = WAIT_W'(MIN_LAT + TIMEOUT);

  seq_state_t        state, next_state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] cnt_lat;
  logic [VEC_W-1:0]  light_lat;
  logic [RGB_W-1:0]  base_lat;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cap_lit;
  logic [RGB_W-1:0]  cap_rgb;

  logic              start_ok;
  logic              lt_accept;
  logic              lt_timeout;
  logic              keep;
  logic              advance;
  logic              more;
  logic              cull_inc;
  logic [ADDR_W:0]   idx_next;

  logic              fifo_push;
  logic              fifo_empty;
  logic              fifo_full;
  lit_tri_t          push_entry;
  lit_tri_t          head_entry;

  // done shares the cycle with IDLE; a start landing on it is not taken.
  assign start_ok   = (state == IDLE) && start && !done;
  assign lt_accept  = (state == WAIT_LT) && lt_valid && (wait_cnt >= LAT_MIN);
  assign lt_timeout = (state == WAIT_LT) && !lt_accept && (wait_cnt == LAT_MAX);
  assign idx_next   = {1'b0, idx} + 1'b1;
  assign more       = idx_next < {1'b0, cnt_lat};

`ifdef LIGHTING_SEQ_CULL_EN
  assign keep = cap_lit;
`else
  assign keep = 1'b1;
`endif

  // A triangle leaves PUSH once it is either written or not meant to be kept.
  assign advance  = lt_timeout || ((state == PUSH) && (!keep || !fifo_full));
  assign cull_inc = (state == PUSH) && !keep;

  assign push_entry.triangle = lt_triangle;
  assign push_entry.rgb      = cap_lit ? cap_rgb : '0;

  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    lt_en      = 1'b0;
    fifo_push  = 1'b0;
    case (state)
      IDLE:    if (start_ok) next_state = (tri_count == '0) ? DRAIN : FETCH;
      FETCH: begin
        mem_rd     = 1'b1;
        mem_addr   = idx;
        next_state = WAIT_RD;
      end
      WAIT_RD: next_state = ISSUE;
      ISSUE: begin
        lt_en      = 1'b1;
        next_state = WAIT_LT;
      end
      WAIT_LT: begin
        if (lt_accept)       next_state = PUSH;
        else if (lt_timeout) next_state = more ? FETCH : DRAIN;
      end
      PUSH: begin
        fifo_push = keep && !fifo_full;
        if (advance) next_state = more ? FETCH : DRAIN;
      end
      DRAIN:   if (fifo_empty) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      idx          <= '0;
      cnt_lat      <= '0;
      light_lat    <= '0;
      base_lat     <= '0;
      wait_cnt     <= '0;
      cap_lit      <= 1'b0;
      cap_rgb      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      cull_count   <= '0;
      lt_triangle  <= '0;
      lt_light_vec <= '0;
      lt_rgb       <= '0;
    end else begin
      done <= (state == DRAIN) && fifo_empty;
      if ((state == DRAIN) && fifo_empty) busy <= 1'b0;

      if (start_ok) begin
        cnt_lat     <= tri_count;
        light_lat   <= light_vec;
        base_lat    <= base_rgb;
        idx         <= '0;
        cull_count  <= '0;
        err_timeout <= 1'b0;
        busy        <= 1'b1;
      end

      if (state == WAIT_RD) begin
        lt_triangle  <= mem_rdata;
        lt_light_vec <= light_lat;
        lt_rgb       <= base_lat;
      end

      if (state == ISSUE)        wait_cnt <= '0;
      else if (state == WAIT_LT) wait_cnt <= wait_cnt + 1'b1;

      if (lt_accept) begin
        cap_lit <= lt_illuminated;
        cap_rgb <= lt_rgb_out;
      end

      if (lt_timeout) err_timeout <= 1'b1;
      if (advance)    idx <= idx_next[ADDR_W-1:0];
      if (cull_inc && (cull_count != 16'hFFFF)) cull_count <= cull_count + 1'b1;
    end
  end

  lit_tri_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .areset    (areset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (out_ready),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (dbg_fifo_count)
  );

  assign out_valid    = !fifo_empty;
  assign out_triangle = head_entry.triangle;
  assign out_rgb      = head_entry.rgb;
  assign dbg_state    = state;

endmodule

// File: tb/tb_lighting_seq.sv
// -----------------------------------------------------------------------------
// tb_lighting_seq
// Directed frames against lighting_seq with a triangle-memory responder, a
// lighting-stage responder and a frame-level model that lists the entries the
// rasterizer must receive, in order.
// -----------------------------------------------------------------------------
module tb_lighting_seq;
  import lighting_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic areset;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         start;
  logic [9:0]   tri_count;
  logic [47:0]  light_vec;
  logic [23:0]  base_rgb;
  logic         busy, done, err_timeout;
  logic [15:0]  cull_count;
  logic         mem_rd;
  logic [9:0]   mem_addr;
  logic [143:0] mem_rdata;
  logic         lt_en;
  logic [143:0] lt_triangle;
  logic [47:0]  lt_light_vec;
  logic [23:0]  lt_rgb;
  logic         lt_valid, lt_illuminated;
  logic [23:0]  lt_rgb_out;
  logic         out_valid, out_ready;
  logic [143:0] out_triangle;
  logic [23:0]  out_rgb;
  logic [2:0]   dbg_state;
  logic [2:0]   dbg_fifo_count;

  lighting_seq dut (
    .clk            (clk),
    .areset         (areset),
    .start          (start),
    .tri_count      (tri_count),
    .light_vec      (light_vec),
    .base_rgb       (base_rgb),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout),
    .cull_count     (cull_count),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .lt_en          (lt_en),
    .lt_triangle    (lt_triangle),
    .lt_light_vec   (lt_light_vec),
    .lt_rgb         (lt_rgb),
    .lt_valid       (lt_valid),
    .lt_illuminated (lt_illuminated),
    .lt_rgb_out     (lt_rgb_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_triangle   (out_triangle),
    .out_rgb        (out_rgb),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen within its cycle bound", name);
  endtask

  // ---------------- frame configuration & model ----------------
  localparam int MIN_LAT = 4;
  localparam int TIMEOUT = 63;

  int           lat_cfg [16];   // 0 = lighting never answers
  bit           lit_cfg [16];
  logic [23:0]  frame_base;
  logic [47:0]  frame_light;

  logic [167:0] exp_q[$];
  int           exp_outs, exp_cull;
  bit           exp_err;
  int           start_cyc;
  int           issue_base, out_base, done_base, mem_base;

  int           issue_n = 0;
  int           out_cnt = 0;
  int           done_cnt = 0;
  int           mem_rd_cnt = 0;
  logic [23:0]  out_rgb_log [64];

  function automatic logic [143:0] tri_of(input logic [9:0] a);
    return {38'h15_5555_5555, a, 38'h2A_AAAA_AAAA, a, 38'h33_3333_3333, a};
  endfunction

  function automatic logic [23:0] rgb_of(input int i);
    return frame_base + 24'(i) * 24'h010203;
  endfunction

  // A result is used only if it lands inside the acceptance window.
  function automatic bit accepted(input int lat);
    return (lat >= MIN_LAT + 1) && (lat <= MIN_LAT + TIMEOUT + 1);
  endfunction

  task automatic set_cfg(input int lat, input bit lit);
    for (int i = 0; i < 16; i++) begin
      lat_cfg[i] = lat;
      lit_cfg[i] = lit;
    end
  endtask

  // ---------------- triangle memory responder ----------------
  initial begin
    logic       rd_pend;
    logic [9:0] rd_addr;
    mem_rdata = {9{16'hDEAD}};
    forever begin
      @(negedge clk);
      rd_pend = mem_rd && !areset;
      rd_addr = mem_addr;
      if (rd_pend) mem_rd_cnt++;
      @(posedge clk);
      #1;
      mem_rdata = rd_pend ? tri_of(rd_addr) : {9{16'hDEAD}};
    end
  end

  // ---------------- lighting responder ----------------
  initial begin
    int          lt_cd;
    int          ri;
    logic        pend_lit;
    logic [23:0] pend_rgb;
    lt_cd = 0;
    pend_lit = 1'b0;
    pend_rgb = '0;
    lt_valid = 1'b0;
    lt_illuminated = 1'b0;
    lt_rgb_out = '0;
    forever begin
      @(negedge clk);
      lt_valid = 1'b0;
      lt_illuminated = 1'b0;
      lt_rgb_out = 24'h5A5A5A;
      if (areset) begin
        lt_cd = 0;
      end else begin
        if (lt_cd > 0) begin
          lt_cd--;
          if (lt_cd == 0) begin
            lt_valid = 1'b1;
            lt_illuminated = pend_lit;
            lt_rgb_out = pend_rgb;
          end
        end
        if (lt_en) begin
          ri = issue_n - issue_base;
          if (ri < 16) begin
            chk("lt_triangle", lt_triangle, tri_of(10'(ri)));
            chk("lt_light_vec", lt_light_vec, frame_light);
            chk("lt_rgb", lt_rgb, frame_base);
            if (lat_cfg[ri] > 0) begin
              lt_cd = lat_cfg[ri];
              pend_lit = lit_cfg[ri];
              pend_rgb = rgb_of(ri);
            end
          end
          issue_n++;
        end
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!areset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h %0h expected no entry", out_triangle, out_rgb);
      end else begin
        chk("out_entry", {out_triangle, out_rgb}, exp_q.pop_front());
      end
      if (out_cnt < 64) out_rgb_log[out_cnt] = out_rgb;
      out_cnt++;
    end
    if (!areset && done) begin
      done_cnt++;
      chk("busy_low_at_done", busy, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int n, input logic [47:0] light, input logic [23:0] base);
    frame_base  = base;
    frame_light = light;
    exp_outs = 0;
    exp_cull = 0;
    exp_err  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!accepted(lat_cfg[i])) begin
        exp_err = 1'b1;
      end else if (lit_cfg[i]) begin
        exp_q.push_back({tri_of(10'(i)), rgb_of(i)});
        exp_outs++;
      end else begin
`ifdef LIGHTING_SEQ_CULL_EN
        exp_cull++;
`else
        exp_q.push_back({tri_of(10'(i)), 24'h000000});
        exp_outs++;
`endif
      end
    end
    issue_base = issue_n;
    out_base   = out_cnt;
    done_base  = done_cnt;
    mem_base   = mem_rd_cnt;
    @(posedge clk);
    #1;
    start     = 1'b1;
    tri_count = 10'(n);
    light_vec = light;
    base_rgb  = base;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    light_vec = ~light;
    base_rgb  = ~base;
  endtask

  task automatic finish_frame(input string name, input int max_cyc, input bit toggle_ready);
    int k;
    k = 0;
    while (done_cnt == done_base && k < max_cyc) begin
      @(posedge clk);
      #1;
      if (toggle_ready) out_ready = cyc[0];
      k++;
    end
    if (done_cnt == done_base) fail_bound({name, "_done"});
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_exp_left"}, exp_q.size(), 0);
    chk({name, "_out_count"}, out_cnt - out_base, exp_outs);
    chk({name, "_cull"}, cull_count, exp_cull);
    chk({name, "_err"}, err_timeout, exp_err);
    chk({name, "_done_pulses"}, done_cnt - done_base, 1);
    chk({name, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctrl"}, {busy, done, err_timeout, mem_rd, lt_en, out_valid}, 6'b0);
    chk({name, "_cull"}, cull_count, 16'h0);
    chk({name, "_mem_addr"}, mem_addr, 10'h0);
    chk({name, "_lt_tri"}, lt_triangle, 144'h0);
    chk({name, "_lt_vec_rgb"}, {lt_light_vec, lt_rgb}, 72'h0);
    chk({name, "_out_data"}, {out_triangle, out_rgb}, 168'h0);
    chk({name, "_state"}, dbg_state, IDLE);
    chk({name, "_fifo_count"}, dbg_fifo_count, 3'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    areset    = 1'b1;
    start     = 1'b0;
    tri_count = '0;
    light_vec = '0;
    base_rgb  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    areset = 1'b0;

    // Frame 1: three lit triangles, result 5 cycles after lt_en.
    set_cfg(5, 1'b1);
    start_frame(3, 48'h0123_4567_89AB, 24'h102030);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        chk("f1_first_valid_latency", cyc - start_cyc, 10);
      end
    end
    if (!found) fail_bound("f1_first_valid");
    finish_frame("f1", 200, 1'b0);
    chk("f1_rgb0", out_rgb_log[out_base], 24'h102030);
    chk("f1_rgb1", out_rgb_log[out_base + 1], 24'h112233);
    chk("f1_rgb2", out_rgb_log[out_base + 2], 24'h122436);

    // Frame 2: four triangles, triangle 1 unlit.
    set_cfg(5, 1'b1);
    lit_cfg[1] = 1'b0;
    start_frame(4, 48'hFEDC_BA98_7654, 24'h0A0B0C);
    finish_frame("f2", 300, 1'b0);
`ifdef LIGHTING_SEQ_CULL_EN
    chk("f2_lit_outputs", out_cnt - out_base, 3);
    chk("f2_cull_one", cull_count, 16'd1);
`else
    chk("f2_all_outputs", out_cnt - out_base, 4);
    chk("f2_unlit_rgb", out_rgb_log[out_base + 1], 24'h000000);
`endif

    // Frame 3: back-pressure fills the FIFO; a start while busy is ignored.
    set_cfg(5, 1'b1);
    out_ready = 1'b0;
    start_frame(6, 48'h0F0F_F0F0_1234, 24'h203040);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (dbg_fifo_count == 3'd4 && dbg_state == PUSH) found = 1'b1;
    end
    if (!found) fail_bound("f3_stall_full");
    @(posedge clk);
    #1;
    start     = 1'b1;
    tri_count = 10'd1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    repeat (20) @(negedge clk);
    chk("f3_held_count", dbg_fifo_count, 3'd4);
    chk("f3_held_state", dbg_state, PUSH);
    chk("f3_held_valid", out_valid, 1'b1);
    finish_frame("f3", 500, 1'b1);
    chk("f3_outputs", out_cnt - out_base, 6);

    // Frame 4: no answer, then an answer one cycle too early, then a normal one.
    set_cfg(5, 1'b1);
    lat_cfg[0] = 0;
    lat_cfg[1] = 4;
    start_frame(3, 48'h1111_2222_3333, 24'h445566);
    while (cyc < start_cyc + 71) @(negedge clk);
    chk("f4_err_before_limit", err_timeout, 1'b0);
    @(negedge clk);
    chk("f4_err_at_limit", err_timeout, 1'b1);
    finish_frame("f4", 400, 1'b0);
    chk("f4_outputs", out_cnt - out_base, 1);
    chk("f4_rgb", out_rgb_log[out_base], 24'h46596C);

    // Frame 5: empty frame; a start coinciding with done is ignored.
    set_cfg(5, 1'b1);
    start_frame(0, 48'h0, 24'h0);
    @(negedge clk);
    chk("f5_busy", busy, 1'b1);
    chk("f5_err_cleared", err_timeout, 1'b0);
    chk("f5_no_done_yet", done, 1'b0);
    @(posedge clk);
    #1;
    start     = 1'b1;
    tri_count = 10'd2;
    @(negedge clk);
    chk("f5_done", done, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("f5_start_on_done_ignored", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("f5_state_idle", dbg_state, IDLE);
    chk("f5_no_mem_rd", mem_rd_cnt - mem_base, 0);
    chk("f5_one_done", done_cnt - done_base, 1);

    // Frame 6: reset while waiting on lighting.
    set_cfg(5, 1'b1);
    start_frame(3, 48'hAAAA_5555_AAAA, 24'h778899);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (dbg_state == WAIT_LT) found = 1'b1;
    end
    if (!found) fail_bound("f6_wait_lt");
    #2;
    areset = 1'b1;
    #1;
    chk_zero("f6_reset");
    repeat (2) @(negedge clk);
    areset = 1'b0;
    exp_q.delete();
    done_base = done_cnt;
    repeat (100) @(negedge clk);
    chk("f6_no_done", done_cnt - done_base, 0);
    chk("f6_idle_busy", busy, 1'b0);

    // Frame 7: normal operation after the reset.
    set_cfg(6, 1'b1);
    start_frame(2, 48'h1357_9BDF_2468, 24'h010101);
    finish_frame("f7", 200, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
